// File: rtl/banked_bram.sv
// ============================================================================
//  Module   : banked_bram
//  Purpose  : N-bank simple-dual-port RAM with a bank-selected write port and
//             an all-banks parallel read port, 1- or 2-cycle read latency.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module banked_bram #(
  parameter int RAM_WIDTH    = 13,
  parameter int NB_ADDRESS   = 10,
  parameter int N_BANKS      = 3,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  localparam int NB_BANK     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                         i_CLK,
  input  logic                         i_reset,
  input  logic                         i_wrEnable,
  input  logic                         i_wrAuto,
  input  logic [NB_BANK-1:0]           i_wrBank,
  input  logic [NB_ADDRESS-1:0]        i_writeAdd,
  input  logic [RAM_WIDTH-1:0]         i_data,
  input  logic                         i_rdEnable,
  input  logic [NB_ADDRESS-1:0]        i_readAdd,
  output logic [N_BANKS*RAM_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic [NB_BANK-1:0]           o_wrPtrBank,
  output logic [NB_ADDRESS-1:0]        o_wrPtrAdd
);

  localparam int               c_DEPTH     = 2 ** NB_ADDRESS;
  localparam logic [NB_BANK-1:0] c_LAST_BANK = NB_BANK'(N_BANKS - 1);

  logic [NB_BANK-1:0]           r_ptr_bank;
  logic [NB_ADDRESS-1:0]        r_ptr_add;
  logic [NB_BANK-1:0]           w_wr_bank;
  logic [NB_ADDRESS-1:0]        w_wr_add;
  logic [N_BANKS-1:0]           w_wr_en;
  logic [N_BANKS*RAM_WIDTH-1:0] w_s1_data;
  logic                         r_s1_valid;

  assign w_wr_bank = i_wrAuto ? r_ptr_bank : i_wrBank;
  assign w_wr_add  = i_wrAuto ? r_ptr_add  : i_writeAdd;

  // Auto pointer walks every address of a bank before moving to the next bank.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_ptr_bank <= '0;
      r_ptr_add  <= '0;
    end else if (i_wrEnable && i_wrAuto) begin
      if (&r_ptr_add) begin
        r_ptr_add  <= '0;
        r_ptr_bank <= (r_ptr_bank == c_LAST_BANK) ? '0 : r_ptr_bank + NB_BANK'(1);
      end else begin
        r_ptr_add <= r_ptr_add + NB_ADDRESS'(1);
      end
    end
  end

  assign o_wrPtrBank = r_ptr_bank;
  assign o_wrPtrAdd  = r_ptr_add;

  always_ff @(posedge i_CLK) begin
    if (i_reset) r_s1_valid <= 1'b0;
    else         r_s1_valid <= i_rdEnable;
  end

  generate
    for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
      logic [RAM_WIDTH-1:0] r_mem [c_DEPTH];
      logic [RAM_WIDTH-1:0] r_lane;

      // Out-of-range bank numbers match no lane, so such writes are dropped.
      assign w_wr_en[k] = i_wrEnable && (w_wr_bank == NB_BANK'(k));

      always_ff @(posedge i_CLK) begin
        if (!i_reset && w_wr_en[k]) r_mem[w_wr_add] <= i_data;
      end

      always_ff @(posedge i_CLK) begin
        if (i_reset) begin
          r_lane <= '0;
        end else if (i_rdEnable) begin
          if (RDW_MODE == 1 && w_wr_en[k] && (w_wr_add == i_readAdd)) r_lane <= i_data;
          else                                                        r_lane <= r_mem[i_readAdd];
        end
      end

      assign w_s1_data[k*RAM_WIDTH +: RAM_WIDTH] = r_lane;
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [N_BANKS*RAM_WIDTH-1:0] r_out_data;
      logic                         r_out_valid;

      always_ff @(posedge i_CLK) begin
        if (i_reset) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_s1_valid;
          if (r_s1_valid) r_out_data <= w_s1_data;
        end
      end

      assign o_data  = r_out_data;
      assign o_valid = r_out_valid;
    end else begin : g_lat1
      assign o_data  = w_s1_data;
      assign o_valid = r_s1_valid;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_banked_bram.sv
// ============================================================================
//  Module   : tb_banked_bram
//  Purpose  : Directed bench for banked_bram; one LAT=1/read-first and one
//             LAT=2/write-first instance share the same stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_banked_bram;

  logic        clk = 1'b0;
  logic        rst, we, au, re;
  logic [1:0]  bk;
  logic [3:0]  wa, ra;
  logic [12:0] din;

  logic [38:0] d1, d2;
  logic        v1, v2;
  logic [1:0]  pb1, pb2;
  logic [3:0]  pa1, pa2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  banked_bram #(.RAM_WIDTH(13), .NB_ADDRESS(4), .N_BANKS(3), .READ_LATENCY(1), .RDW_MODE(0)) dut1 (
    .i_CLK(clk), .i_reset(rst), .i_wrEnable(we), .i_wrAuto(au), .i_wrBank(bk), .i_writeAdd(wa),
    .i_data(din), .i_rdEnable(re), .i_readAdd(ra), .o_data(d1), .o_valid(v1),
    .o_wrPtrBank(pb1), .o_wrPtrAdd(pa1));

  banked_bram #(.RAM_WIDTH(13), .NB_ADDRESS(4), .N_BANKS(3), .READ_LATENCY(2), .RDW_MODE(1)) dut2 (
    .i_CLK(clk), .i_reset(rst), .i_wrEnable(we), .i_wrAuto(au), .i_wrBank(bk), .i_writeAdd(wa),
    .i_data(din), .i_rdEnable(re), .i_readAdd(ra), .o_data(d2), .o_valid(v2),
    .o_wrPtrBank(pb2), .o_wrPtrAdd(pa2));

  typedef struct {
    logic        we, au;
    logic [1:0]  bk;
    logic [3:0]  wa;
    logic [12:0] d;
    logic        re;
    logic [3:0]  ra;
    logic        v1;
    logic [38:0] d1;
    logic        v2;
    logic [38:0] d2;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic a, input logic [1:0] b, input logic [3:0] wad,
                      input logic [12:0] d, input logic r, input logic [3:0] rad, input logic rs);
    we = w; au = a; bk = b; wa = wad; din = d; re = r; ra = rad; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ptr(input string name, input logic [1:0] b, input logic [3:0] a);
    chk({name, " ptr_bank1"}, 64'(pb1), 64'(b));
    chk({name, " ptr_add1"},  64'(pa1), 64'(a));
    chk({name, " ptr_bank2"}, 64'(pb2), 64'(b));
    chk({name, " ptr_add2"},  64'(pa2), 64'(a));
  endtask

  // Contents left by the 49 auto writes: bank b addr a = 16*b + a, except bank0 addr0 = 48.
  function automatic logic [38:0] col(input int a);
    logic [12:0] l0, l1, l2;
    l0 = (a == 0) ? 13'd48 : 13'(a);
    l1 = 13'(16 + a);
    l2 = 13'(32 + a);
    return {l2, l1, l0};
  endfunction

  localparam logic [38:0] c_D5  = {13'h003, 13'h002, 13'h001};
  localparam logic [38:0] c_D7O = {13'h022, 13'h0AA, 13'h011};
  localparam logic [38:0] c_D7N = {13'h022, 13'h155, 13'h011};

  initial begin
    rst = 1'b1; we = 1'b0; au = 1'b0; re = 1'b0; bk = '0; wa = '0; ra = '0; din = '0;

    // Two reset cycles; a write and a read presented meanwhile must be ignored.
    step(1'b1, 1'b1, 2'd0, 4'd0, 13'h1ABC, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0,    1'b0, 4'd0, 1'b1);
    chk("reset valid1", 64'(v1), 64'd0);
    chk("reset data1",  64'(d1), 64'd0);
    chk("reset valid2", 64'(v2), 64'd0);
    chk("reset data2",  64'(d2), 64'd0);
    chk_ptr("reset", 2'd0, 4'd0);

    //        we    au    bk    wa    data       re    ra    v1    d1     v2    d2
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'd5, 13'h001,  1'b0, 4'd0, 1'b0, 39'd0, 1'b0, 39'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 4'd5, 13'h002,  1'b0, 4'd0, 1'b0, 39'd0, 1'b0, 39'd0};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 4'd5, 13'h003,  1'b0, 4'd0, 1'b0, 39'd0, 1'b0, 39'd0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b1, 4'd5, 1'b1, c_D5,  1'b0, 39'd0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b0, 4'd0, 1'b0, c_D5,  1'b1, c_D5};
    tbl[5]  = '{1'b1, 1'b0, 2'd3, 4'd5, 13'h1FFF, 1'b0, 4'd0, 1'b0, c_D5,  1'b0, c_D5};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b1, 4'd5, 1'b1, c_D5,  1'b0, c_D5};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b0, 4'd0, 1'b0, c_D5,  1'b1, c_D5};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 4'd7, 13'h011,  1'b0, 4'd0, 1'b0, c_D5,  1'b0, c_D5};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 4'd7, 13'h022,  1'b0, 4'd0, 1'b0, c_D5,  1'b0, c_D5};
    tbl[10] = '{1'b1, 1'b0, 2'd1, 4'd7, 13'h0AA,  1'b0, 4'd0, 1'b0, c_D5,  1'b0, c_D5};
    tbl[11] = '{1'b1, 1'b0, 2'd1, 4'd7, 13'h155,  1'b1, 4'd7, 1'b1, c_D7O, 1'b0, c_D5};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b1, 4'd7, 1'b1, c_D7N, 1'b1, c_D7N};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b0, 4'd0, 1'b0, c_D7N, 1'b1, c_D7N};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 4'd0, 13'h000,  1'b0, 4'd0, 1'b0, c_D7N, 1'b0, c_D7N};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].we, tbl[i].au, tbl[i].bk, tbl[i].wa, tbl[i].d, tbl[i].re, tbl[i].ra, 1'b0);
      chk($sformatf("vec%0d valid1", i), 64'(v1), 64'(tbl[i].v1));
      chk($sformatf("vec%0d data1", i),  64'(d1), 64'(tbl[i].d1));
      chk($sformatf("vec%0d valid2", i), 64'(v2), 64'(tbl[i].v2));
      chk($sformatf("vec%0d data2", i),  64'(d2), 64'(tbl[i].d2));
      chk_ptr($sformatf("vec%0d", i), 2'd0, 4'd0);
    end

    // Auto writes: 3*DEPTH+1 words; explicit bank/addr fields carry junk that must be ignored.
    for (int i = 0; i < 49; i++) begin
      step(1'b1, 1'b1, 2'd2, 4'd9, 13'(i), 1'b0, 4'd0, 1'b0);
      if (i == 15) chk_ptr("auto 16 words", 2'd1, 4'd0);
      if (i == 47) chk_ptr("auto 48 words", 2'd0, 4'd0);
    end
    chk_ptr("auto 49 words", 2'd0, 4'd1);

    // Back-to-back reads over the whole address range.
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b1, 4'(a), 1'b0);
      chk($sformatf("stream%0d valid1", a), 64'(v1), 64'd1);
      chk($sformatf("stream%0d data1", a),  64'(d1), 64'(col(a)));
      if (a > 0) begin
        chk($sformatf("stream%0d valid2", a), 64'(v2), 64'd1);
        chk($sformatf("stream%0d data2", a),  64'(d2), 64'(col(a - 1)));
      end
    end
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b0, 4'd0, 1'b0);
    chk("stream end valid1", 64'(v1), 64'd0);
    chk("stream end valid2", 64'(v2), 64'd1);
    chk("stream end data2",  64'(d2), 64'(col(15)));

    // Reset in the middle of a read stream discards in-flight reads.
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b1, 4'd1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b1, 4'd4, 1'b1);
    chk("midrst valid1", 64'(v1), 64'd0);
    chk("midrst data1",  64'(d1), 64'd0);
    chk("midrst valid2", 64'(v2), 64'd0);
    chk("midrst data2",  64'(d2), 64'd0);
    chk_ptr("midrst", 2'd0, 4'd0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b1, 4'd3, 1'b0);
    chk("postrst valid1", 64'(v1), 64'd1);
    chk("postrst data1",  64'(d1), 64'(col(3)));
    chk("postrst valid2", 64'(v2), 64'd0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 13'h0, 1'b0, 4'd0, 1'b0);
    chk("postrst2 valid1", 64'(v1), 64'd0);
    chk("postrst2 valid2", 64'(v2), 64'd1);
    chk("postrst2 data2",  64'(d2), 64'(col(3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
